// File: rtl/conv_row_scheduler.sv
// Sequences one convolution pass: per output row, clear the array, then for each
// kernel row fetch an image row and step K weights, then hand the row downstream.
module conv_row_scheduler #(
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int ARRAY_SIZE  = 6,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             start,
    input  logic [1:0]       input_interface_ack,
    input  logic             out_ready,
    output logic [1:0]       input_interface_cmd,
    output logic             kernel_array_clear,
    output logic             kernel_calc_fin,
    output logic             feature_valid,
    output logic [IDX_W-1:0] out_row,
    output logic [IDX_W-1:0] k_row,
    output logic [IDX_W-1:0] k_col,
    output logic             busy,
    output logic             done
);

    if (ARRAY_SIZE != IMG_W - KERNEL_SIZE + 1) begin : g_bad_cfg
        $error("conv_row_scheduler: ARRAY_SIZE must equal IMG_W-KERNEL_SIZE+1");
    end

    localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(KERNEL_SIZE - 1);
    localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(IMG_H - KERNEL_SIZE);
    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_STEP = 2'b01;
    localparam logic [1:0] CMD_LOAD = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_MAC, S_WAIT_OUT} state_t;
    state_t state;

    // An ack only counts against the command currently on the bus.
    logic ack_hit;
    assign ack_hit = (input_interface_cmd != CMD_NOP) && (input_interface_ack == input_interface_cmd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= S_IDLE;
            input_interface_cmd <= CMD_NOP;
            kernel_array_clear  <= 1'b0;
            kernel_calc_fin     <= 1'b0;
            feature_valid       <= 1'b0;
            out_row             <= '0;
            k_row               <= '0;
            k_col               <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else if (!enable) begin
            // Paused: pulses are held so enable-qualified consumers still see each one once.
            input_interface_cmd <= CMD_NOP;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy               <= 1'b1;
                        kernel_array_clear <= 1'b1;
                        state              <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    kernel_array_clear <= 1'b0;
                    state              <= S_LOAD;
                end
                S_LOAD: begin
                    if (ack_hit) begin
                        input_interface_cmd <= CMD_NOP;
                        k_col               <= '0;
                        state               <= S_MAC;
                    end else begin
                        input_interface_cmd <= CMD_LOAD;
                    end
                end
                S_MAC: begin
                    // Each completed command is followed by one NOP cycle so back-to-back STEPs stay distinct.
                    if (ack_hit) begin
                        input_interface_cmd <= CMD_NOP;
                        if (k_col != K_LAST) begin
                            k_col <= k_col + 1'b1;
                        end else if (k_row != K_LAST) begin
                            k_row <= k_row + 1'b1;
                            k_col <= '0;
                            state <= S_LOAD;
                        end else begin
                            kernel_calc_fin <= 1'b1;
                            feature_valid   <= 1'b1;
                            state           <= S_WAIT_OUT;
                        end
                    end else begin
                        input_interface_cmd <= CMD_STEP;
                    end
                end
                S_WAIT_OUT: begin
                    kernel_calc_fin <= 1'b0;
                    if (out_ready) begin
                        feature_valid <= 1'b0;
                        k_row         <= '0;
                        k_col         <= '0;
                        if (out_row != ROW_LAST) begin
                            out_row            <= out_row + 1'b1;
                            kernel_array_clear <= 1'b1;
                            state              <= S_CLEAR;
                        end else begin
                            out_row <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Scoreboard bench: a row/kernel loop model predicts the event stream; a monitor
// compares observed commands and pulses against it, plus pause/hold invariants.
module tb_conv_row_scheduler;
    localparam int IMG_W = 8, IMG_H = 8, K = 3, AS = 6, IDX_W = 4;
    localparam int ROWS = IMG_H - K + 1;

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, start = 1'b0, out_ready = 1'b1;
    logic [1:0] ack = 2'b00;
    logic [1:0] cmd;
    logic clr, fin, fv, busy, done;
    logic [IDX_W-1:0] out_row, k_row, k_col;

    conv_row_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H), .KERNEL_SIZE(K), .ARRAY_SIZE(AS), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
        .input_interface_ack(ack), .out_ready(out_ready),
        .input_interface_cmd(cmd), .kernel_array_clear(clr), .kernel_calc_fin(fin),
        .feature_valid(fv), .out_row(out_row), .k_row(k_row), .k_col(k_col),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, n_done = 0;
    int exp_q[$];
    bit rnd_mode = 0, bad_mode = 0, pause_req = 0, hold_req = 0;
    int fixed_delay = 1, pause_left = 0, wcnt = 0, cur_delay = 0, hold_cnt = 0, fv_row2 = 0;

    task automatic chk(input string name, input int got, input int expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // Event: type 1 CLEAR, 2 LOAD_ROW accepted, 3 STEP accepted, 4 FIN, 5 VALID, 6 DONE
    function automatic int ev(input int t, input int r, input int kr, input int kc);
        return (t << 12) | (r << 8) | (kr << 4) | kc;
    endfunction

    task automatic got_ev(input int e);
        int x;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_extra: got event %h expected none", e);
        end else begin
            x = exp_q.pop_front();
            if (x !== e) begin
                n_fail++;
                $display("FAIL sb_event: got %h expected %h", e, x);
            end
        end
    endtask

    task automatic push_frame();
        for (int r = 0; r < ROWS; r++) begin
            exp_q.push_back(ev(1, r, 0, 0));
            for (int kr = 0; kr < K; kr++) begin
                exp_q.push_back(ev(2, r, kr, 0));
                for (int kc = 0; kc < K; kc++) exp_q.push_back(ev(3, r, kr, kc));
            end
            exp_q.push_back(ev(4, r, 0, 0));
            exp_q.push_back(ev(5, r, 0, 0));
        end
        exp_q.push_back(ev(6, 0, 0, 0));
    endtask

    // Interface / downstream / enable model, driven just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (pause_left > 0) begin
            enable = 1'b0;
            pause_left--;
        end else begin
            enable = 1'b1;
            if (pause_req && cmd == 2'b01 && out_row == 0 && k_row == 1 && k_col == 1) begin
                pause_req = 0; pause_left = 4; enable = 1'b0;
            end else if (rnd_mode && busy && $urandom_range(9) == 0) begin
                pause_left = $urandom_range(3); enable = 1'b0;
            end
        end
        if (!rst_n || (enable && cmd == 2'b00)) begin
            ack = 2'b00; wcnt = 0;
        end else if (!enable) begin
            ack = 2'b01;  // stray acks while paused
        end else begin
            if (wcnt == 0) cur_delay = rnd_mode ? $urandom_range(4) : fixed_delay;
            if (wcnt >= cur_delay) ack = cmd;
            else if (bad_mode && wcnt == 0) ack = ~cmd;
            else ack = 2'b00;
            wcnt++;
        end
        if (hold_req && fv && out_row == 2 && hold_cnt < 10) begin
            out_ready = 1'b0; hold_cnt++;
        end else begin
            out_ready = rnd_mode ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    // Monitor: inputs seen here are exactly what the DUT samples at the next edge.
    logic [1:0] p_cmd, p_ack;
    logic p_en, p_rdy, p_fv, p_clr, p_fin, p_done;
    int p_cnt;
    always @(negedge clk) begin
        if (!rst_n) begin
            p_cmd = 0; p_ack = 0; p_en = 0; p_rdy = 0; p_fv = 0; p_clr = 0; p_fin = 0; p_done = 0; p_cnt = 0;
        end else begin
            if (!p_en) begin
                chk("pause_cmd", cmd, 0);
                chk("pause_counters", {out_row, k_row, k_col}, p_cnt);
                chk("pause_fv", fv, p_fv);
            end else if (p_cmd != 0 && p_ack != p_cmd) begin
                chk("cmd_hold", cmd, p_cmd);
            end
            if (p_fv && !(p_en && p_rdy)) chk("fv_hold", fv, 1);
            if (cmd == 2'b11) chk("cmd_reserved", cmd, 0);
            if (clr && !p_clr) got_ev(ev(1, out_row, k_row, k_col));
            if (enable && cmd != 0 && ack == cmd) got_ev(ev(cmd == 2'b10 ? 2 : 3, out_row, k_row, k_col));
            if (fin && !p_fin) got_ev(ev(4, out_row, 0, 0));
            if (fv && !p_fv) got_ev(ev(5, out_row, 0, 0));
            if (done && !p_done) begin
                got_ev(ev(6, out_row, k_row, k_col));
                chk("done_busy", busy, 0);
                n_done++;
            end
            if (hold_req && fv && out_row == 2) fv_row2++;
            p_cmd = cmd; p_ack = ack; p_en = enable; p_rdy = out_ready;
            p_fv = fv; p_clr = clr; p_fin = fin; p_done = done; p_cnt = {out_row, k_row, k_col};
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_cmd"}, cmd, 0);
        chk({tag, "_clear"}, clr, 0);
        chk({tag, "_fin"}, fin, 0);
        chk({tag, "_fv"}, fv, 0);
        chk({tag, "_counters"}, {out_row, k_row, k_col}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic pulse_start();
        repeat (6) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic run_frame(input string name, input bit poke);
        int d0;
        d0 = n_done;
        push_frame();
        pulse_start();
        for (int c = 0; c < 6000 && n_done == d0; c++) begin
            @(posedge clk);
            #2 start = (poke && c == 30) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        chk({name, "_done_seen"}, n_done, d0 + 1);
        chk({name, "_idle_busy"}, busy, 0);
        chk({name, "_idle_counters"}, {out_row, k_row, k_col}, 0);
        chk({name, "_sb_empty"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;

        run_frame("frame_fast", 0);

        fixed_delay = 4; bad_mode = 1; pause_req = 1; hold_req = 1;
        run_frame("frame_slow", 1);
        chk("pause_taken", pause_req, 0);
        chk("row2_fv_cycles", fv_row2, 11);
        hold_req = 0;

        rnd_mode = 1;
        run_frame("frame_rand0", 0);
        run_frame("frame_rand1", 1);
        rnd_mode = 0; bad_mode = 0; fixed_delay = 1;
        repeat (8) @(posedge clk);

        push_frame();
        pulse_start();
        for (int c = 0; c < 3000 && out_row != 3; c++) @(posedge clk);
        chk("pre_reset_row", out_row, 3);
        chk("pre_reset_busy", busy, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("midreset");
        exp_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        run_frame("frame_after_reset", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
